out_tile_writer: RTL

Downstream stage of the systolic-array control/quantify pipeline. Captures the quantized output-channel rows, one row per cycle while `quantify_en` is high, into a ping-pong buffer. A tile closes on `quantify_add_end`. Full tiles drain to the output-feature-map memory write port over a valid/ready handshake, and `buf_busy` tells the upstream controller to hold off new tiles while both banks are occupied.

---
 rtl/out_tile_writer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/out_tile_writer.sv
// Ping-pong output tile buffer: captures quantized rows into two banks and
// drains completed tiles, in fill order, to the ofmap write port over valid/ready.
//
// bank state | meaning
// B_EMPTY    | free, fill side may start a tile here
// B_FILLING  | rows being captured, tile not yet closed
// B_FULL     | tile closed, waiting for the drain side
// B_DRAINING | rows being emitted on the write port
module out_tile_writer #(
   parameter int PIX = 16,
   parameter int DW  = 8,
   parameter int CH  = 16,
   parameter int AW  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                quantify_en,
   input  logic                quantify_reset,
   input  logic                quantify_add_end,
   input  logic [PIX*DW-1:0]   q_data,
   input  logic [AW-1:0]       out_base_addr,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [PIX*DW-1:0]   wr_data,
   output logic [AW-1:0]       wr_addr,
   output logic                wr_last,
   output logic                tile_done,
   output logic                buf_busy,
   output logic                overflow
);
   localparam int RW = PIX * DW;
   localparam int IW = (CH > 1) ? $clog2(CH) : 1;
   localparam int CW = $clog2(CH + 1);
   localparam logic [CW-1:0] CH_C = CW'(CH);
   localparam logic [AW-1:0] CH_A = AW'(CH);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;

   bank_st_t        bank_st [2];
   bank_st_t        bank_nx [2];
   logic [RW-1:0]   mem [2][CH];
   logic [CW-1:0]   bank_cnt [2];
   logic [AW-1:0]   bank_addr [2];
   logic            fill_sel;
   logic            drain_sel;
   logic [CW-1:0]   fill_idx;
   logic [CW-1:0]   drain_idx;
   logic [AW-1:0]   tile_seq;

   logic            fill_open;
   logic            row_ok;
   logic            row_drop;
   logic            close;
   logic [CW-1:0]   rows_tot;
   logic [AW-1:0]   tile_addr;
   logic            hs;
   logic            done;
   logic            start_cur;
   logic            start_next;
   logic            rd_sel;
   logic [CW-1:0]   rd_row;

   function automatic logic held(input bank_st_t s);
      return (s == B_FULL) || (s == B_DRAINING);
   endfunction

   always_comb begin
      fill_open  = (bank_st[fill_sel] == B_EMPTY) || (bank_st[fill_sel] == B_FILLING);
      row_ok     = quantify_en && !quantify_reset && fill_open && (fill_idx < CH_C);
      row_drop   = quantify_en && !quantify_reset && !row_ok;
      rows_tot   = fill_idx + CW'(row_ok);
      close      = quantify_add_end && !quantify_reset && fill_open && (rows_tot != '0);
      tile_addr  = out_base_addr + tile_seq * CH_A;
      hs         = wr_valid && wr_ready;
      done       = hs && wr_last;
      start_cur  = !wr_valid && (bank_st[drain_sel] == B_FULL);
      // back-to-back drain: the other bank is already waiting when this tile ends
      start_next = done && (bank_st[~drain_sel] == B_FULL);

      bank_nx[0] = bank_st[0];
      bank_nx[1] = bank_st[1];
      if (quantify_reset && fill_open) begin
         bank_nx[fill_sel] = B_EMPTY;
      end else if (close) begin
         bank_nx[fill_sel] = B_FULL;
      end else if (row_ok) begin
         bank_nx[fill_sel] = B_FILLING;
      end
      if (start_cur) bank_nx[drain_sel] = B_DRAINING;
      if (done) bank_nx[drain_sel] = B_EMPTY;
      if (start_next) bank_nx[~drain_sel] = B_DRAINING;
   end

   always_comb begin
      rd_sel = drain_sel;
      rd_row = drain_idx;
      if (start_cur) begin
         rd_row = '0;
      end else if (start_next) begin
         rd_sel = ~drain_sel;
         rd_row = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (row_ok && !reset) mem[fill_sel][fill_idx[IW-1:0]] <= q_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bank_st[0]   <= B_EMPTY;
         bank_st[1]   <= B_EMPTY;
         bank_cnt[0]  <= '0;
         bank_cnt[1]  <= '0;
         bank_addr[0] <= '0;
         bank_addr[1] <= '0;
         fill_sel     <= 1'b0;
         drain_sel    <= 1'b0;
         fill_idx     <= '0;
         drain_idx    <= '0;
         tile_seq     <= '0;
         wr_valid     <= 1'b0;
         wr_data      <= '0;
         wr_addr      <= '0;
         wr_last      <= 1'b0;
         tile_done    <= 1'b0;
         buf_busy     <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         bank_st   <= bank_nx;
         tile_done <= done;
         buf_busy  <= held(bank_st[0]) && held(bank_st[1]);
         if (row_drop) overflow <= 1'b1;

         if (quantify_reset) begin
            fill_idx <= '0;
         end else if (close) begin
            bank_cnt[fill_sel]  <= rows_tot;
            bank_addr[fill_sel] <= tile_addr;
            tile_seq            <= tile_seq + 1'b1;
            fill_sel            <= ~fill_sel;
            fill_idx            <= '0;
         end else if (row_ok) begin
            fill_idx <= fill_idx + 1'b1;
         end

         if (start_cur || start_next || (hs && !wr_last)) begin
            wr_valid  <= 1'b1;
            wr_data   <= mem[rd_sel][rd_row[IW-1:0]];
            wr_addr   <= bank_addr[rd_sel] + AW'(rd_row);
            wr_last   <= (rd_row == bank_cnt[rd_sel] - 1'b1);
            drain_idx <= rd_row + 1'b1;
         end else if (done) begin
            wr_valid <= 1'b0;
            wr_last  <= 1'b0;
         end
         if (done) drain_sel <= ~drain_sel;
      end
   end
endmodule
